// File: rtl/vga_scan_swap_ctrl.sv
// vga_scan_swap_ctrl: VGA scan timing, linear display address and vblank-aligned double-buffer swap.
// Optional build macro SWAP_STATS_EN adds a saturating dropped_frames counter.
module vga_scan_swap_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        frame_done,
    output logic        hsync,
    output logic        vsync,
    output logic        active,
    output logic [18:0] vga_addr,
    output logic        swap,
    output logic        frame_ack,
`ifdef SWAP_STATS_EN
    output logic [15:0] dropped_frames,
`endif
    output logic        busy
);

    localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    typedef enum logic {IDLE, PENDING} state_t;

    state_t      state_q, state_d;
    logic [9:0]  h_q, h_d, v_q, v_d;
    logic        hsync_q, hsync_d, vsync_q, vsync_d, active_q, active_d;
    logic [18:0] addr_q, addr_d;
    logic        swap_q, swap_d, ack_q, ack_d;
    logic        pix_on, vblank, commit;

    always_comb begin
        h_d      = (h_q == H_LAST) ? '0 : h_q + 10'd1;
        v_d      = (h_q != H_LAST) ? v_q : (v_q == V_LAST) ? '0 : v_q + 10'd1;
        pix_on   = (h_q < H_ACT) && (v_q < V_ACT);
        active_d = pix_on;
        hsync_d  = !((h_q >= HS_BEG) && (h_q <= HS_END));
        vsync_d  = !((v_q >= VS_BEG) && (v_q <= VS_END));
        // Running address avoids a v*640 multiply; (0,0) re-anchors it each frame
        addr_d   = (h_q == '0 && v_q == '0) ? '0 : pix_on ? addr_q + 19'd1 : addr_q;
        vblank   = (h_q == '0) && (v_q == V_ACT);
        commit   = vblank && (state_q == PENDING || frame_done);
        swap_d   = swap_q ^ commit;
        ack_d    = commit;
        state_d  = commit ? IDLE : frame_done ? PENDING : state_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            h_q      <= '0;
            v_q      <= '0;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            active_q <= 1'b0;
            addr_q   <= '0;
            swap_q   <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            h_q      <= h_d;
            v_q      <= v_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            active_q <= active_d;
            addr_q   <= addr_d;
            swap_q   <= swap_d;
            ack_q    <= ack_d;
        end
    end

`ifdef SWAP_STATS_EN
    logic [15:0] drop_q, drop_d;

    always_comb begin
        drop_d = (vblank && state_q == IDLE && !frame_done && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) drop_q <= '0;
        else          drop_q <= drop_d;
    end

    assign dropped_frames = drop_q;
`endif

    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign active    = active_q;
    assign vga_addr  = addr_q;
    assign swap      = swap_q;
    assign frame_ack = ack_q;
    assign busy      = (state_q == PENDING);

endmodule

// File: tb/tb_vga_scan_swap_ctrl.sv
// tb_vga_scan_swap_ctrl: scenario tasks on a reduced raster; frame_ack checked against a queue of
// expected commit positions pushed whenever frame_done is driven.
module tb_vga_scan_swap_ctrl;

    localparam int HA = 16, HFP = 2, HS = 4, HB = 3;
    localparam int VA = 12, VFP = 2, VS = 2, VB = 3;
    localparam int HT = HA + HFP + HS + HB;
    localparam int VT = VA + VFP + VS + VB;
    localparam int FT = HT * VT;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        frame_done;
    logic        hsync, vsync, active, swap, frame_ack, busy;
    logic [18:0] vga_addr;
`ifdef SWAP_STATS_EN
    logic [15:0] dropped_frames;
`endif

    vga_scan_swap_ctrl #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .frame_done(frame_done),
        .hsync(hsync),
        .vsync(vsync),
        .active(active),
        .vga_addr(vga_addr),
        .swap(swap),
        .frame_ack(frame_ack),
`ifdef SWAP_STATS_EN
        .dropped_frames(dropped_frames),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, n_ack = 0;
    int p = 0, mh = 0, mv = 0, pend_p = -1;
    bit fresh = 1'b1;
    int exp_ack[$];

    // p is the absolute counter position decoded at the latest edge since reset release
    task automatic tick();
        int e;
        @(posedge clk);
        #1;
        if (reset_n) begin
            if (fresh) begin p = 0; fresh = 1'b0; end else p++;
            mh = (p % FT) % HT;
            mv = (p % FT) / HT;
            if (frame_ack) n_ack++;
            if (frame_ack) begin
                n_chk++;
                if (exp_ack.size() == 0) begin
                    n_fail++; $display("FAIL ack_unexpected got ack at pos %0d required none", p);
                end else begin
                    e = exp_ack.pop_front();
                    if (e != p) begin n_fail++; $display("FAIL ack_position got %0d required %0d", p, e); end
                end
            end else if (exp_ack.size() != 0 && exp_ack[0] <= p) begin
                n_chk++; n_fail++;
                e = exp_ack.pop_front();
                $display("FAIL ack_missing got none at pos %0d required ack at %0d", p, e);
            end
            if (pend_p == p) pend_p = -1;
        end
    endtask

    task automatic run_to(input int fpos);
        int g = 0;
        do begin tick(); g++; end while ((p % FT) != fpos && g < 2 * FT + 2);
        if ((p % FT) != fpos) begin
            n_chk++; n_fail++; $display("FAIL run_to_timeout got pos %0d required %0d", p % FT, fpos);
        end
    endtask

    task automatic pulse_fd();
        int pn, vb, c;
        pn = fresh ? 0 : p + 1;
        if (pend_p < 0) begin
            vb = pn - (pn % FT) + VA * HT;
            c = (pn <= vb) ? vb : vb + FT;
            exp_ack.push_back(c);
            pend_p = c;
        end
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
    endtask

    task automatic test_reset();
        int first = -1, hlow = 0;
        reset_n = 1'b1; frame_done = 1'b0;
        #3 reset_n = 1'b0;
        tick(); tick();
        n_chk++; if (hsync !== 1'b1) begin n_fail++; $display("FAIL rst_hsync got %b required 1", hsync); end
        n_chk++; if (vsync !== 1'b1) begin n_fail++; $display("FAIL rst_vsync got %b required 1", vsync); end
        n_chk++; if (active !== 1'b0) begin n_fail++; $display("FAIL rst_active got %b required 0", active); end
        n_chk++; if (vga_addr !== 19'd0) begin n_fail++; $display("FAIL rst_addr got %0d required 0", vga_addr); end
        n_chk++; if ({swap, frame_ack, busy} !== 3'b000) begin n_fail++; $display("FAIL rst_swap_ack_busy got %b required 000", {swap, frame_ack, busy}); end
        reset_n = 1'b1;
        tick();
        n_chk++; if (active !== 1'b1) begin n_fail++; $display("FAIL first_active got %b required 1", active); end
        n_chk++; if (vga_addr !== 19'd0) begin n_fail++; $display("FAIL first_addr got %0d required 0", vga_addr); end
        for (int i = 0; i < HT; i++) begin
            if (i > 0) tick();
            if (hsync === 1'b0) begin if (first < 0) first = mh; hlow++; end
        end
        n_chk++; if (first != HA + HFP) begin n_fail++; $display("FAIL hsync_start got %0d required %0d", first, HA + HFP); end
        n_chk++; if (hlow != HS) begin n_fail++; $display("FAIL hsync_width got %0d required %0d", hlow, HS); end
    endtask

    task automatic test_frame();
        int act_err = 0, addr_err = 0, sw_err = 0, vlow = 0, last_addr = -1;
        bit exp_act;
        for (int i = 0; i < FT && p != FT - 1; i++) begin
            tick();
            exp_act = (mh < HA) && (mv < VA);
            if (active !== exp_act) act_err++;
            if (exp_act && vga_addr !== 19'(mv * HA + mh)) addr_err++;
            if (vsync === 1'b0) vlow++;
            if (swap !== 1'b0) sw_err++;
            if (mh == HA - 1 && mv == VA - 1) last_addr = int'(vga_addr);
        end
        n_chk++; if (act_err != 0) begin n_fail++; $display("FAIL active_pattern got %0d bad cycles required 0", act_err); end
        n_chk++; if (addr_err != 0) begin n_fail++; $display("FAIL addr_pattern got %0d bad cycles required 0", addr_err); end
        n_chk++; if (last_addr != HA * VA - 1) begin n_fail++; $display("FAIL addr_last got %0d required %0d", last_addr, HA * VA - 1); end
        n_chk++; if (vga_addr !== 19'(HA * VA - 1)) begin n_fail++; $display("FAIL addr_hold got %0d required %0d", vga_addr, HA * VA - 1); end
        n_chk++; if (vlow != VS * HT) begin n_fail++; $display("FAIL vsync_width got %0d required %0d", vlow, VS * HT); end
        n_chk++; if (sw_err != 0) begin n_fail++; $display("FAIL swap_idle got %0d bad cycles required 0", sw_err); end
    endtask

    task automatic test_single_request();
        run_to(4 * HT - 1);
        pulse_fd();
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_rise got %b required 1", busy); end
        run_to(VA * HT - 1);
        n_chk++; if ({busy, swap} !== 2'b10) begin n_fail++; $display("FAIL pre_commit busy,swap got %b required 10", {busy, swap}); end
        tick();
        n_chk++; if ({swap, frame_ack, busy} !== 3'b110) begin n_fail++; $display("FAIL commit swap,ack,busy got %b required 110", {swap, frame_ack, busy}); end
        tick();
        n_chk++; if ({swap, frame_ack} !== 2'b10) begin n_fail++; $display("FAIL post_commit swap,ack got %b required 10", {swap, frame_ack}); end
    endtask

    task automatic test_back_to_back();
        int a0 = n_ack;
        run_to(2 * HT - 1); pulse_fd();
        run_to(3 * HT - 1); pulse_fd();
        run_to(5 * HT - 1); pulse_fd();
        run_to(VA * HT + 5);
        n_chk++; if (n_ack - a0 != 1) begin n_fail++; $display("FAIL b2b_ack_count got %0d required 1", n_ack - a0); end
        n_chk++; if ({swap, busy} !== 2'b00) begin n_fail++; $display("FAIL b2b swap,busy got %b required 00", {swap, busy}); end
    endtask

    task automatic test_vblank_edge();
        run_to(VA * HT - 1);
        pulse_fd();
        n_chk++; if ({swap, frame_ack, busy} !== 3'b110) begin n_fail++; $display("FAIL same_cycle swap,ack,busy got %b required 110", {swap, frame_ack, busy}); end
        run_to((VA + 1) * HT - 1);
        pulse_fd();
        n_chk++; if ({frame_ack, busy} !== 2'b01) begin n_fail++; $display("FAIL late_req ack,busy got %b required 01", {frame_ack, busy}); end
        run_to(VA * HT - 1);
        n_chk++; if ({swap, busy} !== 2'b11) begin n_fail++; $display("FAIL late_wait swap,busy got %b required 11", {swap, busy}); end
        tick();
        n_chk++; if ({swap, frame_ack, busy} !== 3'b010) begin n_fail++; $display("FAIL late_commit swap,ack,busy got %b required 010", {swap, frame_ack, busy}); end
    endtask

    task automatic test_reset_pending();
        int a0;
        run_to(7 * HT - 1);
        pulse_fd();
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL pend_busy got %b required 1", busy); end
        reset_n = 1'b0;
        #2;
        n_chk++; if ({busy, swap, frame_ack, active} !== 4'b0000) begin n_fail++; $display("FAIL async_rst busy,swap,ack,active got %b required 0000", {busy, swap, frame_ack, active}); end
        tick();
        exp_ack.delete();
        pend_p = -1;
        fresh = 1'b1;
        reset_n = 1'b1;
        a0 = n_ack;
        tick();
        n_chk++; if ({active, vga_addr} !== {1'b1, 19'd0}) begin n_fail++; $display("FAIL restart active=%b addr=%0d required active=1 addr=0", active, vga_addr); end
        run_to(VA * HT + 2);
        n_chk++; if (n_ack != a0) begin n_fail++; $display("FAIL lost_req ack_count got %0d required 0", n_ack - a0); end
        n_chk++; if ({swap, busy} !== 2'b00) begin n_fail++; $display("FAIL lost_req swap,busy got %b required 00", {swap, busy}); end
    endtask

`ifdef SWAP_STATS_EN
    task automatic test_stats();
        reset_n = 1'b0;
        #2;
        n_chk++; if (dropped_frames !== 16'd0) begin n_fail++; $display("FAIL drop_rst got %0d required 0", dropped_frames); end
        tick();
        exp_ack.delete();
        pend_p = -1;
        fresh = 1'b1;
        reset_n = 1'b1;
        run_to(VA * HT);
        n_chk++; if (dropped_frames !== 16'd1) begin n_fail++; $display("FAIL drop_f0 got %0d required 1", dropped_frames); end
        run_to(3 * HT - 1);
        pulse_fd();
        run_to(VA * HT);
        n_chk++; if (dropped_frames !== 16'd1) begin n_fail++; $display("FAIL drop_f1 got %0d required 1", dropped_frames); end
        run_to(VA * HT);
        n_chk++; if (dropped_frames !== 16'd2) begin n_fail++; $display("FAIL drop_f2 got %0d required 2", dropped_frames); end
    endtask
`endif

    initial begin
        test_reset();
        test_frame();
        test_single_request();
        test_back_to_back();
        test_vblank_edge();
        test_reset_pending();
`ifdef SWAP_STATS_EN
        test_stats();
`endif
        n_chk++;
        if (exp_ack.size() != 0) begin n_fail++; $display("FAIL ack_outstanding got %0d pending required 0", exp_ack.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_scan_swap_ctrl.md
# vga_scan_swap_ctrl

Display-side scan and buffer-swap controller for the double-buffered frame store. It generates 640x480@60 VGA timing and the 19-bit linear scan address `vga_addr` that drives the address arbiter's display port. It also produces the arbiter's `swap` select. A renderer "frame complete" request is accepted at any time, but the swap is committed only at the start of vertical blank, so the display never shows a torn frame.

## Interface
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16 / `H_SYNC`, 96 / `H_BP`, 48: horizontal porch and sync, in pixels
- `V_ACTIVE`, 480: visible lines
- `V_FP`, 10 / `V_SYNC`, 2 / `V_BP`, 33: vertical porch and sync, in lines
- `clk`  in  1  pixel clock (25 MHz), single clock domain
- `reset_n`  in  1  asynchronous, active-low reset
- `frame_done`  in  1  renderer pulse: back buffer complete
- `hsync`  out  1  horizontal sync, active-low
- `vsync`  out  1  vertical sync, active-low
- `active`  out  1  visible-pixel strobe
- `vga_addr`  out  19  linear display address, 0..307199
- `swap`  out  1  buffer select to arbiter; toggles once per committed swap
- `frame_ack`  out  1  one-cycle pulse when a swap is committed
- `busy`  out  1  swap request pending (renderer must not start overwriting)

## Operation
- Internal counters `h` (0..799, wrap to 0) and `v` (0..524, advances when `h` wraps, wraps to 0).
- Decode, all registered, one cycle behind the counters:
  - `active` = (`h` < 640) && (`v` < 480)
  - `hsync` low for `h` in 656..751
  - `vsync` low for `v` in 490..491
- `vga_addr`:
  - Increment register, no multiplier.
  - Loaded with 0 when the counters are at (0,0).
  - +1 after each active pixel.
  - Holds its value outside the active area.
  - Equals `v*640+h` whenever `active`=1.
- Swap FSM:
  - IDLE: on `frame_done`=1 go to PENDING and assert `busy`.
  - PENDING: further `frame_done` pulses are absorbed (one swap only). At vblank start, i.e. counters at (`h`=0, `v`=480):
    - toggle `swap`
    - pulse `frame_ack`
    - go to IDLE and clear `busy`
- Simultaneous events: `frame_done`=1 in IDLE on the vblank-start cycle commits that same cycle. The request is not deferred a frame.
- `frame_done` arriving after vblank start is deferred to the next frame's vblank start.
- Width rules: counters are 10 bits; `vga_addr` is 19 bits, and 307199 < 2^19.

## Timing
- Reset values: `h`=0, `v`=0, `hsync`=1, `vsync`=1, `active`=0, `vga_addr`=0, `swap`=0, `frame_ack`=0, `busy`=0, FSM=IDLE.
- First rising edge after `reset_n` deasserts: `active`=1 and `vga_addr`=0.
- Output latency: 1 cycle from the counter state. `active`, `hsync`, `vsync`, `vga_addr` and `swap` are mutually aligned.
- `swap` and `frame_ack` change on the same edge where `active` first falls for line 480.
- `frame_done` to `busy`: 1 cycle.
- `frame_done` to `frame_ack`: at most 420,001 cycles (one frame plus 1).
- Reset mid-operation: all state returns to reset values immediately. Any pending request is lost; the renderer re-issues it.
- Line period 800 cycles; frame period 420,000 cycles.

## Configuration
- `SWAP_STATS_EN` defined:
  - Adds output `dropped_frames` [15:0], reset 0.
  - Increments at each vblank start where the FSM is IDLE and `frame_done`=0, meaning the display repeats a frame.
  - Saturates at 0xFFFF.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset held, then released:
  - all outputs at their reset values while held
  - the cycle after release: `active`=1, `vga_addr`=0
  - `hsync` low for exactly 96 cycles starting at pixel 656
- Full frame with no request:
  - `vga_addr` reaches 307199 on the last active pixel, then holds
  - `vsync` low for exactly 1600 cycles
  - `swap` stays 0
- `frame_done` pulse at line 100:
  - `busy` rises 1 cycle later
  - at line 480, pixel 0: `swap` goes 0→1, `frame_ack` is high for 1 cycle, `busy` drops
- Three `frame_done` pulses in one frame: exactly one `swap` toggle and one `frame_ack`.
- `frame_done` on the exact vblank-start cycle: commits that cycle. `frame_done` at line 481: commits at the next frame's line 480.
- `reset_n` pulsed low while PENDING at line 300: `busy`=0, `swap`=0, counters restart; no `frame_ack` at the next vblank start.
- With `SWAP_STATS_EN`: run 3 frames with requests only in frame 2 → `dropped_frames`=2.
